// File: rtl/mcp48x2_dual_dac.sv
// mcp48x2_dual_dac: SPI mode-0 driver for MCP4802/4812/4822, writes channels A/B then pulses LDACn.
// Defining MCP48X2_SHDN_EN adds the shdn_a/shdn_b inputs that drive the frame SHDN bit.
module mcp48x2_dual_dac #(
    parameter int CLK_DIV  = 10,
    parameter int DAC_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                en_a,
    input  logic                en_b,
    input  logic [DAC_BITS-1:0] code_a,
    input  logic [DAC_BITS-1:0] code_b,
    input  logic                gain2x_a,
    input  logic                gain2x_b,
`ifdef MCP48X2_SHDN_EN
    input  logic                shdn_a,
    input  logic                shdn_b,
`endif
    output logic                done,
    output logic                CSn,
    output logic                SCK,
    output logic                SDI,
    output logic                LDACn
);
    localparam int PAD = 12 - DAC_BITS;

    if (DAC_BITS != 8 && DAC_BITS != 10 && DAC_BITS != 12) begin : g_bad_bits
        $error("DAC_BITS must be 8, 10 or 12");
    end
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("CLK_DIV must be in 1..255");
    end

    typedef enum logic [2:0] {IDLE, FRAME_A, GAP, FRAME_B, LDAC_SETUP, LDAC_PULSE} state_t;
    state_t state, state_nxt;

    logic        act_a, act_b;
    logic [11:0] just_a, just_b;
    logic [15:0] frame_a, frame_b, first, frame_b_q, shreg;
    logic [7:0]  div;
    logic [4:0]  h;
    logic        en_b_q, nop, tick, idle, accept, in_frame, frame_end, gap_end;

`ifdef MCP48X2_SHDN_EN
    assign act_a = ~shdn_a;
    assign act_b = ~shdn_b;
`else
    assign act_a = 1'b1;
    assign act_b = 1'b1;
`endif

    assign just_a    = 12'(code_a) << PAD;
    assign just_b    = 12'(code_b) << PAD;
    assign frame_a   = {1'b0, 1'b0, ~gain2x_a, act_a, just_a};
    assign frame_b   = {1'b1, 1'b0, ~gain2x_b, act_b, just_b};
    assign first     = en_a ? frame_a : frame_b;
    assign idle      = state == IDLE;
    assign in_ready  = idle;
    assign accept    = idle && in_valid;
    assign tick      = div == 8'(CLK_DIV - 1);
    assign in_frame  = state == FRAME_A || state == FRAME_B;
    assign frame_end = in_frame && tick && &h;
    assign gap_end   = state == GAP && tick && h[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (in_valid) state_nxt = en_a ? FRAME_A : en_b ? FRAME_B : IDLE;
            FRAME_A:    if (frame_end) state_nxt = en_b_q ? GAP : LDAC_SETUP;
            GAP:        if (gap_end) state_nxt = FRAME_B;
            FRAME_B:    if (frame_end) state_nxt = LDAC_SETUP;
            LDAC_SETUP: if (tick) state_nxt = LDAC_PULSE;
            LDAC_PULSE: if (tick) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // h counts SCK half-periods; even->odd tick raises SCK, odd tick lowers it and advances SDI
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div       <= '0;
            h         <= '0;
            shreg     <= '0;
            frame_b_q <= '0;
            en_b_q    <= 1'b0;
            nop       <= 1'b0;
            done      <= 1'b0;
            CSn       <= 1'b1;
            SCK       <= 1'b0;
            SDI       <= 1'b0;
            LDACn     <= 1'b1;
        end else begin
            div  <= (idle || tick) ? '0 : div + 8'd1;
            h    <= (idle || gap_end) ? '0 : h + 5'(tick);
            nop  <= accept && !en_a && !en_b;
            done <= nop || (state == LDAC_PULSE && tick);
            if (accept) begin
                en_b_q    <= en_b;
                frame_b_q <= frame_b;
            end
            if (accept && (en_a || en_b)) begin
                CSn   <= 1'b0;
                SDI   <= first[15];
                shreg <= {first[14:0], 1'b0};
            end
            if (gap_end) begin
                CSn   <= 1'b0;
                SDI   <= frame_b_q[15];
                shreg <= {frame_b_q[14:0], 1'b0};
            end
            if (in_frame && tick) begin
                SCK <= ~h[0];
                if (h[0] && &h) begin
                    CSn <= 1'b1;
                    SDI <= 1'b0;
                end else if (h[0]) begin
                    SDI   <= shreg[15];
                    shreg <= {shreg[14:0], 1'b0};
                end
            end
            if (state == LDAC_SETUP && tick) LDACn <= 1'b0;
            if (state == LDAC_PULSE && tick) LDACn <= 1'b1;
        end
    end
endmodule

// File: doc/mcp48x2_dual_dac.md
# mcp48x2_dual_dac

Parametrised SPI driver for the MCP4802/4812/4822 dual-channel DAC family, successor to the single-word MCP4812 driver. It accepts one request carrying codes for channels A and B, serialises one or two 16-bit command frames in SPI mode 0, then pulses LDACn once so that both outputs update together. It sits between the acquisition/pulser control logic and the off-chip DAC that sets analogue levels (gain, threshold).

## Interface
Parameters:
- CLK_DIV, default 10: clk cycles per SCK half-period; legal range 1..255.
- DAC_BITS, default 10: resolution, legal values 8 (4802), 10 (4812) and 12 (4822); any other value is an elaboration error.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request strobe; qualified by in_ready.
- in_ready  out  1  high exactly when FSM is IDLE.
- en_a, en_b  in  1 each  write channel A / B in this request.
- code_a, code_b  in  DAC_BITS each  DAC codes.
- gain2x_a, gain2x_b  in  1 each  1 selects 2x gain (frame bit GAn = 0).
- shdn_a, shdn_b  in  1 each  1 shuts down the channel (frame bit SHDNn = 0); present only with MCP48X2_SHDN_EN.
- done  out  1  one-cycle pulse when a request completes.
- CSn, SCK, SDI, LDACn  out  1 each  DAC pins; all registered.

## Operation
- Reset values: CSn=1, SCK=0, SDI=0, LDACn=1, done=0, FSM=IDLE, in_ready=1.
- Request handling:
  - Accept on a rising clk edge with in_valid & in_ready.
  - Capture all request inputs at acceptance; they are don't-care afterwards.
- Frame format, sent MSB first:
  - bit15 = A/Bn (0 = A); bit14 = 0; bit13 = ~gain2x; bit12 = ~shdn.
  - bits 11..0 = code left-justified, with unused LSBs driven 0.
- FSM states: IDLE -> FRAME_A -> GAP -> FRAME_B -> LDAC_SETUP -> LDAC_PULSE -> IDLE.
  - FRAME_A is skipped if en_a=0; FRAME_B is skipped if en_b=0.
  - GAP is entered only when both channels are enabled.
  - en_a=en_b=0: accepted; done pulses on the next cycle; no pin activity; LDACn is not pulsed.
- SPI:
  - SDI changes only when SCK falls (or at CSn assertion); the DAC samples on the rising SCK edge.
  - SCK is low whenever CSn is high.
  - Bit counter runs 0..15 per frame; the shift register is reloaded from the captured frame at frame start.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously); the request in flight is discarded; no done pulse.
- in_valid while busy: ignored, not queued.

## Timing
D = CLK_DIV. E0 = acceptance edge. All times are edges after E0.
- E0: CSn falls and SDI = bit15 of the first frame.
- Bit k (0..15):
  - SCK rises at E0+(2k+1)D.
  - SCK falls at E0+(2k+2)D; SDI advances at the same edge.
- Frame end: at E0+32D, SCK falls and CSn rises on the same edge.
- Two frames:
  - CSn stays high for 2D cycles (GAP).
  - Second frame CSn falls at E0+34D and ends at E0+66D.
- Let F be the edge where the last frame ends (32D for one frame, 66D for two):
  - LDACn low at F+D, high at F+2D.
  - done pulses and in_ready rises at F+2D.
- Total latency: 34D cycles for one channel, 68D cycles for two.
- Back-to-back: a new request can be accepted on the edge where done is high's following cycle; earliest E0' = F+2D+1 (IDLE entered at F+2D).
- CLK_DIV=1 is legal: SCK = clk/2.

## Configuration
- MCP48X2_SHDN_EN defined: shdn_a/shdn_b ports exist and drive frame bit12 = ~shdn.
- MCP48X2_SHDN_EN undefined: the ports are absent and bit12 is fixed at 1 (channel always active).

## Test plan
- DAC_BITS=12, D=2, en_a=1 only, code_a=0xABC, gain2x_a=0 -> one frame 0x3ABC; CSn low for 64 cycles; LDACn low at cycles 66..67; done at 68.
- DAC_BITS=12, D=2, both channels, code_a=0x000 gain2x_a=0, code_b=0x123 gain2x_b=1 -> frames 0x3000 then 0x9123; CSn high for 4 cycles between frames; one LDACn pulse; done at cycle 136.
- DAC_BITS=8, code_a=0xA5 -> frame 0x3A50. DAC_BITS=10, code_a=0x3FF -> frame 0x3FFC.
- With MCP48X2_SHDN_EN, shdn_b=1, code_b=0x555 (12-bit) -> frame 0x8555. en_a=en_b=0 -> done one cycle after acceptance; pins idle.
- Assert reset at cycle 20 of frame A -> CSn=1, SCK=0, LDACn=1 immediately; in_ready=1; no done. A following request runs a full normal transaction.
- Random in_valid pulses while busy -> ignored; SCK is never high with CSn high; exactly 16 rising SCK edges per CSn-low window.
